// File: rtl/bp_serial_link_scheduler.sv
// -----------------------------------------------------------------------------
// bp_serial_link_scheduler
//
// Purpose:
//   Round-robin arbiter and serializer. Several requesters each present a
//   data_width_p-bit message. One message is granted at a time, latched, and
//   sent over a narrow link as num_packets_p beats of packet_width_p bits,
//   LSBs first. A grant can take place on the final-beat handshake, so that
//   consecutive messages leave no idle cycle between them.
//
// Ports:
//   clk_i         in   1                       clock, rising edge
//   reset_i       in   1                       asynchronous, active-high reset
//   valid_i       in   [els_p]                 per-requester message valid
//   data_i        in   [els_p][data_width_p]   per-requester message
//   ready_o       out  [els_p]                 grant/accept, one-hot or zero
//   link_v_o      out  1                       link beat valid
//   link_data_o   out  [packet_width_p]        link beat payload
//   link_id_o     out  [id_width_lp]           owner of the current beat
//   link_last_o   out  1                       final beat of a message
//   link_ready_i  in   1                       downstream beat accept
//   busy_o        out  1                       a message is being sent
// -----------------------------------------------------------------------------
module bp_serial_link_scheduler #(
    parameter int data_width_p  = 20,
    parameter int num_packets_p = 3,
    parameter int els_p         = 4,
    localparam int packet_width_p = (data_width_p + num_packets_p - 1) / num_packets_p,
    localparam int id_width_lp    = (els_p > 1) ? $clog2(els_p) : 1
) (
    input  logic                                     clk_i,
    input  logic                                     reset_i,
    input  logic [els_p-1:0]                         valid_i,
    input  logic [els_p-1:0][data_width_p-1:0]       data_i,
    output logic [els_p-1:0]                         ready_o,
    output logic                                     link_v_o,
    output logic [packet_width_p-1:0]                link_data_o,
    output logic [id_width_lp-1:0]                   link_id_o,
    output logic                                     link_last_o,
    input  logic                                     link_ready_i,
    output logic                                     busy_o
);

    localparam int padded_width_lp = packet_width_p * num_packets_p;
    localparam int cnt_width_lp    = (num_packets_p > 1) ? $clog2(num_packets_p) : 1;
    localparam logic [cnt_width_lp-1:0] cnt_last_lp = cnt_width_lp'(num_packets_p - 1);
    localparam logic [id_width_lp-1:0]  grant_rst_lp = id_width_lp'(els_p - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    state_e                                      r_state;
    state_e                                      w_state_next;
    logic [cnt_width_lp-1:0]                     r_cnt;
    logic [id_width_lp-1:0]                      r_last_grant;
    logic [id_width_lp-1:0]                      r_id;
    logic [num_packets_p-1:0][packet_width_p-1:0] r_data;

    logic                                        w_send;
    logic                                        w_any_valid;
    logic                                        w_hs;
    logic                                        w_last_beat;
    logic                                        w_grant_en;
    logic                                        w_hi_found;
    logic                                        w_lo_found;
    logic [id_width_lp-1:0]                      w_hi_id;
    logic [id_width_lp-1:0]                      w_lo_id;
    logic [data_width_p-1:0]                     w_hi_data;
    logic [data_width_p-1:0]                     w_lo_data;
    logic [id_width_lp-1:0]                      w_grant_id;
    logic [data_width_p-1:0]                     w_grant_data;
    logic [padded_width_lp-1:0]                  w_grant_padded;
    logic [els_p-1:0]                            w_ready;
    logic [packet_width_p-1:0]                   w_beat;

    assign w_send      = (r_state == SEND);
    assign w_any_valid = |valid_i;
    assign w_hs        = w_send & link_ready_i;
    assign w_last_beat = (r_cnt == cnt_last_lp);

    // A grant happens from IDLE, or on the final-beat handshake so the next
    // message follows without a bubble. Reset suppresses it so ready_o stays
    // low while reset_i is held.
    assign w_grant_en = ~reset_i & w_any_valid & (~w_send | (w_hs & w_last_beat));

    // Round-robin pick: the lowest valid index above last_grant wins; if there
    // is none, the lowest valid index at or below last_grant wins (wrap).
    always_comb begin
        w_hi_found = 1'b0;
        w_lo_found = 1'b0;
        w_hi_id    = '0;
        w_lo_id    = '0;
        w_hi_data  = '0;
        w_lo_data  = '0;
        for (int j = 0; j < els_p; j++) begin
            if (valid_i[j] && (j > int'(r_last_grant)) && !w_hi_found) begin
                w_hi_found = 1'b1;
                w_hi_id    = id_width_lp'(j);
                w_hi_data  = data_i[j];
            end else begin
                w_hi_found = w_hi_found;
            end
            if (valid_i[j] && (j <= int'(r_last_grant)) && !w_lo_found) begin
                w_lo_found = 1'b1;
                w_lo_id    = id_width_lp'(j);
                w_lo_data  = data_i[j];
            end else begin
                w_lo_found = w_lo_found;
            end
        end
        if (w_hi_found) begin
            w_grant_id   = w_hi_id;
            w_grant_data = w_hi_data;
        end else begin
            w_grant_id   = w_lo_id;
            w_grant_data = w_lo_data;
        end
    end

    // Zero-extend the granted message to a whole number of beats.
    always_comb begin
        w_grant_padded                    = '0;
        w_grant_padded[data_width_p-1:0]  = w_grant_data;
    end

    // One-hot accept for the granted requester in the grant cycle only.
    always_comb begin
        w_ready = '0;
        for (int j = 0; j < els_p; j++) begin
            if (w_grant_en && (w_grant_id == id_width_lp'(j))) begin
                w_ready[j] = 1'b1;
            end else begin
                w_ready[j] = 1'b0;
            end
        end
    end

    // Beat payload selected from the latched message by the beat index.
    always_comb begin
        w_beat = '0;
        for (int k = 0; k < num_packets_p; k++) begin
            if (r_cnt == cnt_width_lp'(k)) begin
                w_beat = r_data[k];
            end else begin
                w_beat = w_beat;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant_en) begin
                    w_state_next = SEND;
                end else begin
                    w_state_next = IDLE;
                end
            end
            SEND: begin
                if (w_hs && w_last_beat) begin
                    if (w_any_valid) begin
                        w_state_next = SEND;
                    end else begin
                        w_state_next = IDLE;
                    end
                end else begin
                    w_state_next = SEND;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Beat counter: cleared on grant, advanced on non-final handshakes.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_cnt <= '0;
        end else if (w_grant_en) begin
            r_cnt <= '0;
        end else if (w_hs && !w_last_beat) begin
            r_cnt <= r_cnt + cnt_width_lp'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // Grant capture: message, owner id and round-robin pointer.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_last_grant <= grant_rst_lp;
            r_id         <= '0;
            r_data       <= '0;
        end else if (w_grant_en) begin
            r_last_grant <= w_grant_id;
            r_id         <= w_grant_id;
            r_data       <= w_grant_padded;
        end else begin
            r_last_grant <= r_last_grant;
            r_id         <= r_id;
            r_data       <= r_data;
        end
    end

    assign ready_o     = w_ready;
    assign link_v_o    = w_send;
    assign busy_o      = w_send;
    assign link_data_o = w_beat;
    assign link_id_o   = r_id;
    assign link_last_o = w_send & w_last_beat;

endmodule

// File: tb/tb_bp_serial_link_scheduler.sv
// -----------------------------------------------------------------------------
// tb_bp_serial_link_scheduler
//
// Two builds of the scheduler: A (20-bit messages, 3 beats, 4 requesters) and
// B (8-bit messages, 1 beat, 1 requester). Each has a reference model that
// pushes expected beats into a queue when a grant is predicted and pops them
// as the link hands beats off.
// -----------------------------------------------------------------------------
module tb_bp_serial_link_scheduler;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // build A
    logic [3:0]        a_valid;
    logic [3:0][19:0]  a_data;
    logic [3:0]        a_ready;
    logic              a_v;
    logic [6:0]        a_dout;
    logic [1:0]        a_id;
    logic              a_last;
    logic              a_lready;
    logic              a_busy;

    // build B
    logic [0:0]        b_valid;
    logic [0:0][7:0]   b_data;
    logic [0:0]        b_ready;
    logic              b_v;
    logic [7:0]        b_dout;
    logic [0:0]        b_id;
    logic              b_last;
    logic              b_lready;
    logic              b_busy;

    bp_serial_link_scheduler #(
        .data_width_p (20),
        .num_packets_p(3),
        .els_p        (4)
    ) dut_a (
        .clk_i       (clk),
        .reset_i     (rst),
        .valid_i     (a_valid),
        .data_i      (a_data),
        .ready_o     (a_ready),
        .link_v_o    (a_v),
        .link_data_o (a_dout),
        .link_id_o   (a_id),
        .link_last_o (a_last),
        .link_ready_i(a_lready),
        .busy_o      (a_busy)
    );

    bp_serial_link_scheduler #(
        .data_width_p (8),
        .num_packets_p(1),
        .els_p        (1)
    ) dut_b (
        .clk_i       (clk),
        .reset_i     (rst),
        .valid_i     (b_valid),
        .data_i      (b_data),
        .ready_o     (b_ready),
        .link_v_o    (b_v),
        .link_data_o (b_dout),
        .link_id_o   (b_id),
        .link_last_o (b_last),
        .link_ready_i(b_lready),
        .busy_o      (b_busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [6:0] data;
        logic [1:0] id;
        logic       last;
        int         beat;
    } beat_t;

    beat_t      q_a[$];
    logic [7:0] q_b[$];
    logic [1:0] obs_ids[$];
    int         m_last_a;

    function automatic int rr_pick(input int last, input logic [3:0] v);
        for (int off = 1; off <= 4; off++) begin
            if (v[(last + off) % 4]) return (last + off) % 4;
        end
        return -1;
    endfunction

    // Reference model and scoreboard for build A, evaluated mid-cycle.
    initial begin
        m_last_a = 3;
        forever begin
            @(negedge clk);
            if (rst) begin
                q_a.delete();
                m_last_a = 3;
                check_eq("a_rst_v", 32'(a_v), 32'd0);
                check_eq("a_rst_last", 32'(a_last), 32'd0);
                check_eq("a_rst_busy", 32'(a_busy), 32'd0);
                check_eq("a_rst_ready", 32'(a_ready), 32'd0);
            end else begin
                int         g;
                logic [3:0] exp_ready;
                g = -1;
                check_eq("a_link_v", 32'(a_v), 32'(q_a.size() > 0));
                check_eq("a_busy", 32'(a_busy), 32'(q_a.size() > 0));
                if (a_valid != 4'b0000 && (q_a.size() == 0 || (q_a.size() == 1 && a_lready)))
                    g = rr_pick(m_last_a, a_valid);
                exp_ready = (g >= 0) ? 4'(4'b0001 << g) : 4'b0000;
                check_eq("a_ready", 32'(a_ready), 32'(exp_ready));
                if (q_a.size() > 0) begin
                    check_eq("a_beat_data", 32'(a_dout), 32'(q_a[0].data));
                    check_eq("a_beat_id", 32'(a_id), 32'(q_a[0].id));
                    check_eq("a_beat_last", 32'(a_last), 32'(q_a[0].last));
                    if (a_lready) begin
                        if (q_a[0].beat == 0) obs_ids.push_back(a_id);
                        void'(q_a.pop_front());
                    end
                end
                if (g >= 0) begin
                    m_last_a = g;
                    for (int k = 0; k < 3; k++) begin
                        beat_t      b;
                        logic [19:0] sh;
                        sh     = a_data[g] >> (7 * k);
                        b.data = sh[6:0];
                        b.id   = 2'(g);
                        b.last = (k == 2);
                        b.beat = k;
                        q_a.push_back(b);
                    end
                end
            end
        end
    end

    // Reference model and scoreboard for build B.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                q_b.delete();
                check_eq("b_rst_v", 32'(b_v), 32'd0);
                check_eq("b_rst_ready", 32'(b_ready), 32'd0);
            end else begin
                logic grant;
                grant = b_valid[0] && (q_b.size() == 0 || (q_b.size() == 1 && b_lready));
                check_eq("b_link_v", 32'(b_v), 32'(q_b.size() > 0));
                check_eq("b_ready", 32'(b_ready), 32'(grant));
                if (q_b.size() > 0) begin
                    check_eq("b_beat_data", 32'(b_dout), 32'(q_b[0]));
                    check_eq("b_beat_id", 32'(b_id), 32'd0);
                    check_eq("b_beat_last", 32'(b_last), 32'd1);
                    if (b_lready) void'(q_b.pop_front());
                end
                if (grant) q_b.push_back(b_data[0]);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Directed stimulus.
    initial begin
        logic [6:0] held;
        logic [19:0] d3;
        rst      = 1'b1;
        a_valid  = 4'b0001;
        a_data   = '0;
        a_lready = 1'b1;
        b_valid  = 1'b1;
        b_data   = '0;
        b_lready = 1'b1;
        step(3);
        rst     = 1'b0;
        a_valid = 4'b0000;
        b_valid = 1'b0;
        step(2);

        // single message from requester 2
        a_data[2] = 20'hABCDE;
        a_valid   = 4'b0100;
        step(1);
        a_valid = 4'b0000;
        check_eq("t1_beat0", 32'(a_dout), 32'h5E);
        check_eq("t1_id", 32'(a_id), 32'd2);
        check_eq("t1_last0", 32'(a_last), 32'd0);
        step(1);
        check_eq("t1_beat1", 32'(a_dout), 32'h79);
        check_eq("t1_last1", 32'(a_last), 32'd0);
        step(1);
        check_eq("t1_beat2", 32'(a_dout), 32'h2A);
        check_eq("t1_last2", 32'(a_last), 32'd1);
        step(3);

        // all four requesters, fresh reset: order 0,1,2,3,0 with no gaps
        rst = 1'b1;
        step(1);
        rst       = 1'b0;
        a_data[0] = 20'h12345;
        a_data[1] = 20'hFEDCB;
        a_data[2] = 20'h0F0F0;
        a_data[3] = 20'hA5A5A;
        obs_ids.delete();
        a_valid = 4'b1111;
        step(15);
        a_valid = 4'b0000;
        step(4);
        check_eq("rr_count", 32'(obs_ids.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            int exp_id;
            int got_id;
            exp_id = (i == 4) ? 0 : i;
            got_id = (i < obs_ids.size()) ? int'(obs_ids[i]) : -1;
            check_eq("rr_order", 32'(got_id), 32'(exp_id));
        end

        // stall on beat 1, then requester 3 rises on the final-beat handshake
        a_valid = 4'b0010;
        step(1);
        a_valid = 4'b0000;
        step(1);
        a_lready = 1'b0;
        a_valid  = 4'b0001;
        held     = a_dout;
        repeat (5) begin
            step(1);
            check_eq("stall_hold", 32'(a_dout), 32'(held));
            check_eq("stall_no_ready", 32'(a_ready), 32'd0);
            check_eq("stall_last", 32'(a_last), 32'd0);
        end
        a_valid  = 4'b0000;
        a_lready = 1'b1;
        step(1);
        a_valid = 4'b1000;
        #1;
        check_eq("b2b_ready", 32'(a_ready), 32'h8);
        step(1);
        a_valid = 4'b0000;
        d3 = a_data[3];
        check_eq("b2b_v", 32'(a_v), 32'd1);
        check_eq("b2b_id", 32'(a_id), 32'd3);
        check_eq("b2b_beat0", 32'(a_dout), 32'(d3[6:0]));
        step(4);

        // reset after beat 0 of a message from requester 1
        a_valid = 4'b0010;
        step(1);
        a_valid = 4'b0000;
        step(1);
        rst = 1'b1;
        #1;
        check_eq("abort_v", 32'(a_v), 32'd0);
        check_eq("abort_busy", 32'(a_busy), 32'd0);
        a_valid = 4'b0011;
        step(2);
        check_eq("abort_ready", 32'(a_ready), 32'd0);
        rst = 1'b0;
        step(1);
        a_valid = 4'b0000;
        check_eq("post_rst_v", 32'(a_v), 32'd1);
        check_eq("post_rst_id", 32'(a_id), 32'd0);
        step(5);

        // single-beat, single-requester build streaming every cycle
        b_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            b_data[0] = 8'($urandom);
            step(1);
            check_eq("b_stream_v", 32'(b_v), 32'd1);
            check_eq("b_stream_last", 32'(b_last), 32'd1);
        end
        b_valid = 1'b0;
        step(3);

        check_eq("a_drained", 32'(q_a.size()), 32'd0);
        check_eq("b_drained", 32'(q_b.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
